// File: rtl/xmint_arb_mux.sv
// rtl/xmint_arb_mux.sv - N-channel packet-locking arbiter/mux with a single registered output stage
module xmint_arb_mux #(
  parameter int N              = 3,
  parameter int MUX_DATA_WIDTH = 32,
  parameter int ARB_MODE       = 1,
  localparam int SEL_W         = $clog2(N)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N-1:0]                        in_valid,
  input  logic [N-1:0][MUX_DATA_WIDTH-1:0]    in_data,
  input  logic [N-1:0]                        in_last,
  output logic [N-1:0]                        in_ready,
  output logic                                out_valid,
  output logic [MUX_DATA_WIDTH-1:0]           out_data,
  output logic                                out_last,
  output logic [SEL_W-1:0]                    out_sel,
  input  logic                                out_ready
);

  localparam logic [0:0]       ST_UNLOCKED = 1'b0;
  localparam logic [0:0]       ST_LOCKED   = 1'b1;
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(N - 1);

  logic [0:0]                r_state;
  logic [SEL_W-1:0]          r_lock_ch;
  logic [SEL_W-1:0]          r_ptr;
  logic                      r_out_valid;
  logic [MUX_DATA_WIDTH-1:0] r_out_data;
  logic                      r_out_last;
  logic [SEL_W-1:0]          r_out_sel;

  logic                      w_load_en;
  logic                      w_found;
  logic [SEL_W-1:0]          w_gidx;
  logic [N-1:0]              w_grant;
  logic                      w_accept;
  logic                      w_last;
  int                        w_idx;

  assign w_load_en = !r_out_valid || out_ready;

  // Pick the granted channel: the lock owner while locked, otherwise first valid from r_ptr upward
  // (scanning downward in priority so the last assignment is the nearest channel to r_ptr).
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    if (r_state == ST_LOCKED) begin
      w_found = in_valid[r_lock_ch];
      w_gidx  = r_lock_ch;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        w_idx = int'(r_ptr) + k;
        if (w_idx >= N) w_idx = w_idx - N;
        if (in_valid[w_idx]) begin
          w_found = 1'b1;
          w_gidx  = SEL_W'(w_idx);
        end
      end
    end
  end

  // One-hot grant and ready; nothing is accepted while reset is asserted.
  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_gidx] = 1'b1;
    in_ready = (!rst && w_load_en) ? w_grant : '0;
  end

  assign w_accept = w_found && w_load_en && !rst;
  assign w_last   = in_last[w_gidx];

  // Output register stage plus lock/pointer state updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
      r_lock_ch   <= '0;
      r_state     <= ST_UNLOCKED;
    end else begin
      if (w_load_en) begin
        if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_data  <= in_data[w_gidx];
          r_out_last  <= w_last;
          r_out_sel   <= w_gidx;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      if (w_accept) begin
        if (w_last) begin
          r_state <= ST_UNLOCKED;
          if (ARB_MODE == 1) begin
            r_ptr <= (w_gidx == LAST_CH) ? '0 : w_gidx + 1'b1;
          end
        end else begin
          r_state   <= ST_LOCKED;
          r_lock_ch <= w_gidx;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_xmint_arb_mux.sv
// tb/tb_xmint_arb_mux.sv - directed self-checking bench for xmint_arb_mux
module tb_xmint_arb_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;

  logic [2:0]       in_valid = '0;
  logic [2:0]       in_last  = '0;
  logic [2:0][31:0] in_data  = '0;

  logic [2:0]  a_in_ready, b_in_ready;
  logic        a_out_valid, b_out_valid, a_out_last, b_out_last;
  logic [31:0] a_out_data, b_out_data;
  logic [1:0]  a_out_sel, b_out_sel;

  logic [4:0]       c_in_valid = '0;
  logic [4:0]       c_in_last  = '0;
  logic [4:0][31:0] c_in_data  = '0;
  logic [4:0]       c_in_ready;
  logic             c_out_valid, c_out_last;
  logic [31:0]      c_out_data;
  logic [2:0]       c_out_sel;

  int n_checks = 0;
  int n_fail   = 0;

  xmint_arb_mux #(.N(3), .MUX_DATA_WIDTH(32), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_last(a_out_last), .out_sel(a_out_sel), .out_ready(out_ready));

  xmint_arb_mux #(.N(3), .MUX_DATA_WIDTH(32), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_last(b_out_last), .out_sel(b_out_sel), .out_ready(out_ready));

  xmint_arb_mux #(.N(5), .MUX_DATA_WIDTH(32), .ARB_MODE(1)) dut_n5 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data), .in_last(c_in_last),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_last(c_out_last), .out_sel(c_out_sel), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = '0; in_last = '0; c_in_valid = '0; c_in_last = '0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = '1; in_last = '1; c_in_valid = '1; out_ready = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b exp 000", a_in_ready); end
    n_checks++; if (c_in_ready !== 5'b00000) begin n_fail++; $display("FAIL rst_ready5: got %b exp 00000", c_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", a_out_valid); end
    n_checks++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h exp 0", a_out_data); end
    n_checks++; if (a_out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b exp 0", a_out_last); end
    n_checks++; if (a_out_sel !== 2'd0) begin n_fail++; $display("FAIL rst_sel: got %0d exp 0", a_out_sel); end
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid5: got %b exp 0", c_out_valid); end
    rst = 1'b0; in_valid = '0; in_last = '0; c_in_valid = '0; c_in_last = '0;
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    in_valid = 3'b111; in_last = 3'b111;
    in_data[0] = 32'h1000_0000; in_data[1] = 32'h1000_0001; in_data[2] = 32'h1000_0002;
    for (int c = 0; c < 6; c++) begin
      e = c % 3;
      #1;
      n_checks++; if (a_in_ready !== (3'b001 << e)) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b exp %b", c, a_in_ready, 3'b001 << e); end
      @(negedge clk);
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_sel !== 2'(e) || a_out_data !== (32'h1000_0000 + 32'(e))) begin
        n_fail++; $display("FAIL rr_out[%0d]: got v=%b sel=%0d data=%h exp v=1 sel=%0d", c, a_out_valid, a_out_sel, a_out_data, e);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    in_valid = 3'b101; in_last = 3'b111;
    in_data[0] = 32'hF000_0000; in_data[2] = 32'hF000_0002;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (b_in_ready !== 3'b001) begin n_fail++; $display("FAIL fp_ready[%0d]: got %b exp 001", c, b_in_ready); end
      @(negedge clk);
      n_checks++;
      if (b_out_valid !== 1'b1 || b_out_sel !== 2'd0 || b_out_data !== 32'hF000_0000) begin
        n_fail++; $display("FAIL fp_out[%0d]: got v=%b sel=%0d data=%h exp v=1 sel=0 data=f0000000", c, b_out_valid, b_out_sel, b_out_data);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_packet_lock();
    do_reset();
    in_valid = 3'b010; in_last = 3'b000;
    in_data[0] = 32'hB000_0000; in_data[1] = 32'hB100_0000;
    #1;
    n_checks++; if (a_in_ready !== 3'b010) begin n_fail++; $display("FAIL lock_ready0: got %b exp 010", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_sel !== 2'd1 || a_out_last !== 1'b0 || a_out_data !== 32'hB100_0000) begin n_fail++; $display("FAIL lock_beat1: got sel=%0d last=%b data=%h exp sel=1 last=0 data=b1000000", a_out_sel, a_out_last, a_out_data); end
    in_valid = 3'b011; in_data[1] = 32'hB100_0001;
    #1;
    n_checks++; if (a_in_ready !== 3'b010) begin n_fail++; $display("FAIL lock_ready1: got %b exp 010", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_sel !== 2'd1 || a_out_data !== 32'hB100_0001) begin n_fail++; $display("FAIL lock_beat2: got sel=%0d data=%h exp sel=1 data=b1000001", a_out_sel, a_out_data); end
    in_last = 3'b010; in_data[1] = 32'hB100_0002;
    #1;
    n_checks++; if (a_in_ready !== 3'b010) begin n_fail++; $display("FAIL lock_ready2: got %b exp 010", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_sel !== 2'd1 || a_out_last !== 1'b1 || a_out_data !== 32'hB100_0002) begin n_fail++; $display("FAIL lock_beat3: got sel=%0d last=%b data=%h exp sel=1 last=1 data=b1000002", a_out_sel, a_out_last, a_out_data); end
    in_valid = 3'b001; in_last = 3'b001;
    #1;
    n_checks++; if (a_in_ready !== 3'b001) begin n_fail++; $display("FAIL lock_release: got %b exp 001", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_sel !== 2'd0 || a_out_data !== 32'hB000_0000) begin n_fail++; $display("FAIL lock_next: got sel=%0d data=%h exp sel=0 data=b0000000", a_out_sel, a_out_data); end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 3'b001; in_last = 3'b001; in_data[0] = 32'hA5A5_0001;
    @(negedge clk);
    out_ready = 1'b0; in_data[0] = 32'hA5A5_0002;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (a_in_ready !== 3'b000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b exp 000", c, a_in_ready); end
      @(negedge clk);
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 32'hA5A5_0001 || a_out_sel !== 2'd0 || a_out_last !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b data=%h sel=%0d last=%b exp v=1 data=a5a50001 sel=0 last=1", c, a_out_valid, a_out_data, a_out_sel, a_out_last);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 3'b001) begin n_fail++; $display("FAIL bp_resume_ready: got %b exp 001", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hA5A5_0002) begin n_fail++; $display("FAIL bp_next: got v=%b data=%h exp v=1 data=a5a50002", a_out_valid, a_out_data); end
    in_valid = '0;
    #1;
    n_checks++; if (a_in_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready: got %b exp 000", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b exp 0", a_out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    in_valid = 3'b100; in_last = 3'b000; in_data[2] = 32'hC200_0000;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd2) begin n_fail++; $display("FAIL mid_beat1: got v=%b sel=%0d exp v=1 sel=2", a_out_valid, a_out_sel); end
    rst = 1'b1; in_valid = 3'b111;
    #1;
    n_checks++; if (a_in_ready !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ready: got %b exp 000", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0 || a_out_sel !== 2'd0) begin n_fail++; $display("FAIL mid_rst_out: got v=%b sel=%0d exp v=0 sel=0", a_out_valid, a_out_sel); end
    rst = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 3'b001) begin n_fail++; $display("FAIL mid_after_ready: got %b exp 001", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd0) begin n_fail++; $display("FAIL mid_after_out: got v=%b sel=%0d exp v=1 sel=0", a_out_valid, a_out_sel); end
    in_valid = '0;
  endtask

  task automatic test_wrap5();
    do_reset();
    c_in_valid = 5'b01000; c_in_last = 5'b11111;
    c_in_data[0] = 32'h5000_0000; c_in_data[3] = 32'h5000_0003; c_in_data[4] = 32'h5000_0004;
    #1;
    n_checks++; if (c_in_ready !== 5'b01000) begin n_fail++; $display("FAIL wrap_ready3: got %b exp 01000", c_in_ready); end
    @(negedge clk);
    n_checks++; if (c_out_sel !== 3'd3) begin n_fail++; $display("FAIL wrap_sel3: got %0d exp 3", c_out_sel); end
    c_in_valid = 5'b10001;
    #1;
    n_checks++; if (c_in_ready !== 5'b10000) begin n_fail++; $display("FAIL wrap_ready4: got %b exp 10000", c_in_ready); end
    @(negedge clk);
    n_checks++; if (c_out_sel !== 3'd4 || c_out_data !== 32'h5000_0004) begin n_fail++; $display("FAIL wrap_sel4: got sel=%0d data=%h exp sel=4 data=50000004", c_out_sel, c_out_data); end
    #1;
    n_checks++; if (c_in_ready !== 5'b00001) begin n_fail++; $display("FAIL wrap_ready0: got %b exp 00001", c_in_ready); end
    @(negedge clk);
    n_checks++; if (c_out_sel !== 3'd0 || c_out_data !== 32'h5000_0000) begin n_fail++; $display("FAIL wrap_sel0: got sel=%0d data=%h exp sel=0 data=50000000", c_out_sel, c_out_data); end
    #1;
    n_checks++; if (c_in_ready !== 5'b10000) begin n_fail++; $display("FAIL wrap_ready4b: got %b exp 10000", c_in_ready); end
    @(negedge clk);
    n_checks++; if (c_out_sel !== 3'd4) begin n_fail++; $display("FAIL wrap_sel4b: got %0d exp 4", c_out_sel); end
    c_in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_wrap5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
